// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default widths, reset PC, well-known
// instruction encodings and the fetch FSM state type.
package riscv_pkg;

  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and IF/ID register.
// Optional macro IF_MISALIGN_CHECK_EN adds the sticky misaligned-redirect flag misalign_o.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int                       DATA_W    = DEF_DATA_W,
  parameter int                       MEM_DEPTH = 1024,
  parameter logic [DATA_W-1:0]        RESET_PC  = DATA_W'(DEF_RESET_PC),
  localparam int                      AW        = $clog2(MEM_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] target_i,
  output logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] ifid_instr_o,
  output logic [DATA_W-1:0] ifid_pc_o,
  output logic [DATA_W-1:0] ifid_pc4_o,
  output logic              ifid_valid_o,
  output logic              halted_o
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic             misalign_o
`endif
);

  fetch_state_t      state;
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] pc4_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] tgt_aligned;
  logic              tgt_bad;

  assign pc4_p0      = pc_p0 + DATA_W'(4);
  assign tgt_aligned = {target_i[DATA_W-1:2], 2'b00};

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;
  assign tgt_bad    = (target_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^target_i[1:0];
  assign tgt_bad       = 1'b0;
`endif

  // p0: PC and fetch control; the IMEM address comes straight from the PC register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= BOOT;
      pc_p0    <= RESET_PC;
      instr_p1 <= DATA_W'(INSTR_NOP);
      pc_p1    <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, HALT: begin
          if (redirect_i) begin
            // a misaligned target parks the stage instead of fetching garbage
            vld_p1 <= 1'b0;
            if (tgt_bad) begin
              state <= HALT;
`ifdef IF_MISALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              pc_p0 <= tgt_aligned;
              state <= RUN;
            end
          end else if (stall_i) begin
            state <= state;
          end else if (state == RUN) begin
            // p1: IF/ID capture of the word addressed this cycle
            pc_p0    <= pc4_p0;
            instr_p1 <= q;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc4_p0;
            vld_p1   <= 1'b1;
            if (q == DATA_W'(INSTR_EBREAK)) state <= HALT;
          end else begin
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign addr         = pc_p0[AW+1:2];
  assign ifid_instr_o = instr_p1;
  assign ifid_pc_o    = pc_p1;
  assign ifid_pc4_o   = pc4_p1;
  assign ifid_valid_o = vld_p1;
  assign halted_o     = (state == HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus queues per-edge expectations,
// a monitor pops and compares them shortly after every rising edge.
module tb_if_fetch_stage;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [9:0]  addr;
  logic [31:0] imem_q;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        valid;
  logic        halted;
`ifdef IF_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  logic [31:0] mem [1024];

  typedef struct {
    logic [9:0]  a;
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] p4;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch_stage #(.DATA_W(32), .MEM_DEPTH(1024), .RESET_PC(32'h0)) dut (
    .CLK(clk),
    .RST(rst),
    .stall_i(stall),
    .redirect_i(redirect),
    .target_i(target),
    .addr(addr),
    .q(imem_q),
    .ifid_instr_o(instr),
    .ifid_pc_o(pc),
    .ifid_pc4_o(pc4),
    .ifid_valid_o(valid),
    .halted_o(halted)
`ifdef IF_MISALIGN_CHECK_EN
    ,.misalign_o(misalign)
`endif
  );

  assign imem_q = mem[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void chk_all(input string tag, input exp_t e);
    chk({tag, ".addr"},  32'(addr),   32'(e.a));
    chk({tag, ".valid"}, 32'(valid),  32'(e.v));
    chk({tag, ".instr"}, instr,       e.i);
    chk({tag, ".pc"},    pc,          e.p);
    chk({tag, ".pc4"},   pc4,         e.p4);
    chk({tag, ".halt"},  32'(halted), 32'(e.h));
  endfunction

  // Drive one cycle of inputs and queue what the IF/ID outputs must show after that edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                      input logic [9:0] a, input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic [31:0] p4, input logic h);
    exp_t e;
    stall    = st;
    redirect = rd;
    target   = tg;
    e.a = a; e.v = v; e.i = i; e.p = p; e.p4 = p4; e.h = h;
    sb.push_back(e);
    @(posedge clk);
    #3;
  endtask

  // Monitor: compares the oldest expectation against the outputs after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all("edge", e);
      end
    end
  end

  initial begin
    exp_t r;
    logic [31:0] t_skip;
`ifdef IF_MISALIGN_CHECK_EN
    t_skip = 32'h0000_000C;
`else
    t_skip = 32'h0000_000E;
`endif
    for (int k = 0; k < 1024; k++) mem[k] = NOP;
    mem[0]    = 32'h0000_0011;
    mem[1]    = 32'h0000_0022;
    mem[2]    = 32'h0000_0033;
    mem[3]    = EBRK;
    mem[16]   = 32'h0000_0044;
    mem[17]   = 32'h0000_0055;
    mem[1023] = 32'h0000_00AB;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0;
    #1;
    r.a = 10'd0; r.v = 1'b0; r.i = NOP; r.p = 32'h0; r.p4 = 32'h0; r.h = 1'b0;
    chk_all("reset", r);
`ifdef IF_MISALIGN_CHECK_EN
    chk("reset.misalign", 32'(misalign), 32'd0);
`endif
    @(posedge clk);
    #3;
    rst = 1'b0;

    //   st  rd  target        addr   v  instr          pc            pc4           h
    step(0, 0, 32'h0,        10'd0,  0, NOP,           32'h0,        32'h0,        0); // BOOT
    step(0, 0, 32'h0,        10'd1,  1, 32'h11,        32'h0,        32'h4,        0);
    step(0, 0, 32'h0,        10'd2,  1, 32'h22,        32'h4,        32'h8,        0);
    for (int k = 0; k < 3; k++)
      step(1, 0, 32'h0,      10'd2,  1, 32'h22,        32'h4,        32'h8,        0);
    step(0, 0, 32'h0,        10'd3,  1, 32'h33,        32'h8,        32'hC,        0);
    step(1, 1, 32'h40,       10'd16, 0, 32'h33,        32'h8,        32'hC,        0);
    step(0, 0, 32'h0,        10'd17, 1, 32'h44,        32'h40,       32'h44,       0);
    step(0, 1, t_skip,       10'd3,  0, 32'h44,        32'h40,       32'h44,       0);
    step(0, 0, 32'h0,        10'd4,  1, EBRK,          32'hC,        32'h10,       1);
    step(0, 0, 32'h0,        10'd4,  0, EBRK,          32'hC,        32'h10,       1);
    step(1, 0, 32'h0,        10'd4,  0, EBRK,          32'hC,        32'h10,       1);
    step(0, 0, 32'h0,        10'd4,  0, EBRK,          32'hC,        32'h10,       1);
    step(0, 1, 32'h0,        10'd0,  0, EBRK,          32'hC,        32'h10,       0);
    step(0, 0, 32'h0,        10'd1,  1, 32'h11,        32'h0,        32'h4,        0);
    step(0, 1, 32'hFFC,      10'd1023, 0, 32'h11,      32'h0,        32'h4,        0);
    step(0, 0, 32'h0,        10'd0,  1, 32'hAB,        32'hFFC,      32'h1000,     0);
    step(0, 0, 32'h0,        10'd1,  1, 32'h11,        32'h1000,     32'h1004,     0);
    step(0, 1, 32'hFFFF_FFFC,10'd1023, 0, 32'h11,      32'h1000,     32'h1004,     0);
    step(0, 0, 32'h0,        10'd0,  1, 32'hAB,        32'hFFFF_FFFC,32'h0,        0);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    r.a = 10'd0; r.v = 1'b0; r.i = NOP; r.p = 32'h0; r.p4 = 32'h0; r.h = 1'b0;
    chk_all("midrst", r);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step(0, 1, 32'h40,       10'd0,  0, NOP,           32'h0,        32'h0,        0); // redirect ignored in BOOT
    step(0, 0, 32'h0,        10'd1,  1, 32'h11,        32'h0,        32'h4,        0);

`ifdef IF_MISALIGN_CHECK_EN
    step(0, 1, 32'h22,       10'd1,  0, 32'h11,        32'h0,        32'h4,        1);
    chk("mis.set", 32'(misalign), 32'd1);
    step(0, 0, 32'h0,        10'd1,  0, 32'h11,        32'h0,        32'h4,        1);
    step(0, 1, 32'h40,       10'd16, 0, 32'h11,        32'h0,        32'h4,        0);
    chk("mis.sticky", 32'(misalign), 32'd1);
    step(0, 0, 32'h0,        10'd17, 1, 32'h44,        32'h40,       32'h44,       0);
`endif

    stall = 1'b0; redirect = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RISC-V core. It sits directly upstream of the instruction ROM (IMEM): it drives the ROM word address, takes the fetched word back, and registers it with its PC into the IF/ID pipeline register for decode. It owns the program counter, handles branch/jump redirects and pipeline stalls, and stops fetching on EBREAK.

## Interface
- `DATA_W`, 32, instruction and PC width
- `MEM_DEPTH`, 1024, IMEM depth in words; `AW = $clog2(MEM_DEPTH)`
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (word aligned)
- `CLK  in  1  clock; all state updates on the rising edge`
- `RST  in  1  asynchronous, active-high reset`
- `stall_i  in  1  hold PC and IF/ID contents`
- `redirect_i  in  1  load PC from target_i (branch/jump taken)`
- `target_i  in  DATA_W  redirect byte address`
- `addr  out  AW  IMEM word address`
- `q  in  DATA_W  IMEM read data; combinational function of addr`
- `ifid_instr_o  out  DATA_W  registered instruction`
- `ifid_pc_o  out  DATA_W  registered PC of that instruction`
- `ifid_pc4_o  out  DATA_W  registered PC+4`
- `ifid_valid_o  out  1  IF/ID slot holds a real instruction`
- `halted_o  out  1  high in HALT state`
- `misalign_o  out  1  sticky misaligned-redirect flag (only with IF_MISALIGN_CHECK_EN)`

## Operation
- `addr = pc[AW+1:2]`. PC wraps modulo 2^32, and `addr` wraps modulo `MEM_DEPTH`.
- FSM states:
  - BOOT: entered on reset. Lasts exactly one cycle, then goes to RUN. PC holds and `ifid_valid_o` stays 0.
  - RUN: normal fetch.
  - HALT: entered when RUN captures `q == 32'h0010_0073` (EBREAK) into IF/ID.
- Per-edge priority in RUN and HALT:
  1. redirect_i: `pc <= {target_i[31:2],2'b00}`, `ifid_valid_o <= 0`, state becomes RUN. Redirect overrides stall_i.
  2. stall_i: PC, all IF/ID registers and the state hold.
  3. Otherwise in RUN: `pc <= pc+4`, `ifid_instr_o <= q`, `ifid_pc_o <= pc`, `ifid_pc4_o <= pc+4`, `ifid_valid_o <= 1`.
  4. Otherwise in HALT: PC holds and `ifid_valid_o <= 0`. The other IF/ID fields hold.
- EBREAK is passed to decode as valid. Instructions after it are not fetched until a redirect arrives.
- Redirect during BOOT is ignored.
- Reset outputs: `pc = RESET_PC`, `ifid_instr_o = 32'h0000_0013` (NOP), `ifid_pc_o = 0`, `ifid_pc4_o = 0`, `ifid_valid_o = 0`, `halted_o = 0`, `misalign_o = 0`.
- Reset asserted mid-operation: all of the above are forced immediately (asynchronous) and the state returns to BOOT.

## Timing
- Fetch latency is 1 cycle. The word at `addr` during cycle n appears on the IF/ID outputs after edge n.
- After reset release, the first valid instruction (at `RESET_PC`) appears in IF/ID 2 edges later: BOOT, then the RUN capture.
- Redirect penalty is one bubble. After the redirect edge, `ifid_valid_o = 0` for one cycle and `addr` already points at the target.
- `halted_o` rises on the same edge that captures EBREAK.
- No combinational path from any input to `addr`. `addr` depends only on the PC register.

## Configuration
- Macro: `IF_MISALIGN_CHECK_EN`.
- Defined:
  - Port `misalign_o` exists.
  - A redirect with `target_i[1:0] != 0` does not load the PC. Instead it sets `misalign_o` (sticky until reset), clears `ifid_valid_o`, and forces the state to HALT.
  - A later aligned redirect still leaves HALT, but `misalign_o` stays set.
- Undefined: the port is absent and `target_i[1:0]` is silently dropped.

## Structure
- Shared package `riscv_pkg` holds:
  - `DATA_W` default
  - `RESET_PC` default
  - `INSTR_NOP = 32'h0000_0013`
  - `INSTR_EBREAK = 32'h0010_0073`
  - FSM enum `fetch_state_t {BOOT, RUN, HALT}`
- No sub-module. A single module contains the PC register, the FSM and the IF/ID register. Only IMEM is instantiated externally, beside this block.

## Test plan
- Reset, release, no stalls, IMEM preloaded with words `0x11,0x22,0x33` at addr 0..2 -> `addr` goes 0,0,1,2. IF/ID shows `(0x11,pc 0)`, then `(0x22,pc 4)`, then `(0x33,pc 8)`. `ifid_valid_o` is first 1 on the 2nd edge after release.
- Running at pc=8, `stall_i` high for 3 cycles -> `addr` stays 2 and IF/ID is unchanged for 3 cycles, then fetch resumes at pc=12.
- `redirect_i` with `target_i=0x40` while `stall_i=1` -> next cycle `addr=16` with `ifid_valid_o=0`; the following edge captures pc=0x40 as valid.
- EBREAK at pc=0x0C -> IF/ID holds the EBREAK as valid and `halted_o=1`. Next edge `ifid_valid_o=0`, and `addr` stays 4 indefinitely. A later redirect to 0x0 returns the block to RUN.
- PC at `0xFFC` with `MEM_DEPTH=1024` -> next `addr=0` while `ifid_pc4_o=0x1000`. Asserting `RST` mid-cycle immediately zeroes `ifid_valid_o`, and PC returns to `RESET_PC`.
- With `IF_MISALIGN_CHECK_EN`: redirect to `0x22` -> `misalign_o=1`, `halted_o=1`, and PC is unchanged.
